// File: rtl/s2mm_seq_pkg.sv
// s2mm_seq_pkg
// Shared types and constants for the S2MM command sequencer.
//   s2mm_cmd_t : 72-bit AXI DataMover S2MM command word layout
//   state_e    : sequencer FSM states
//   STS_*      : bit positions inside the 8-bit DataMover status byte
//   ERR_*      : bit positions inside the 5-bit err_code output
//   TYPE_INCR  : command TYPE bit for incrementing bursts
// Optional feature macro used by the sequencer: S2MM_SEQ_WRAP_EN.
package s2mm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        type_incr;
    logic [22:0] btt;
  } s2mm_cmd_t;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;
  localparam int STS_TAG_HI = 3;

  localparam int ERR_SLVERR = 0;
  localparam int ERR_DECERR = 1;
  localparam int ERR_INTERR = 2;
  localparam int ERR_UNEXP  = 3;
  localparam int ERR_TAG    = 4;

  localparam logic TYPE_INCR = 1'b1;

  // Assemble a command word: no realignment, no EOF, incrementing burst.
  function automatic s2mm_cmd_t build_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                          input logic [22:0] btt);
    s2mm_cmd_t c;
    c.rsvd      = 4'd0;
    c.tag       = tag;
    c.saddr     = addr;
    c.drr       = 1'b0;
    c.eof       = 1'b0;
    c.dsa       = 6'd0;
    c.type_incr = TYPE_INCR;
    c.btt       = btt;
    return c;
  endfunction

endpackage

// File: rtl/s2mm_sts_check.sv
// s2mm_sts_check
// Combinational decode of one DataMover S2MM status byte against the tag of
// the oldest outstanding command.
//   sts        in  8  status byte [7]OKAY [6]SLVERR [5]DECERR [4]INTERR [3:0]TAG
//   exp_tag    in  4  tag the next status must carry
//   none_outst in  1  no command is awaiting status
//   good       out 1  status completes a block cleanly
//   err_bits   out 5  {tag_mismatch, unexpected, INTERR, DECERR, SLVERR}
module s2mm_sts_check
  import s2mm_seq_pkg::*;
(
  input  logic [7:0] sts,
  input  logic [3:0] exp_tag,
  input  logic       none_outst,
  output logic       good,
  output logic [4:0] err_bits
);

  // Error classification; a tag compare is meaningless when nothing is outstanding.
  always_comb begin
    err_bits             = 5'd0;
    err_bits[ERR_SLVERR] = sts[STS_SLVERR];
    err_bits[ERR_DECERR] = sts[STS_DECERR];
    err_bits[ERR_INTERR] = sts[STS_INTERR];
    err_bits[ERR_UNEXP]  = none_outst;
    err_bits[ERR_TAG]    = !none_outst && (sts[STS_TAG_HI:0] != exp_tag);
    good                 = sts[STS_OKAY] && (err_bits == 5'd0);
  end

endmodule

// File: rtl/s2mm_cmd_sequencer.sv
// s2mm_cmd_sequencer
// Issues AXI DataMover S2MM commands that carve a DDR region into cfg_nblk
// blocks of cfg_btt bytes, and checks the returning status stream (tag order
// and error bits), counting completed blocks.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable                level: rise starts a run, fall requests a drain
//   cfg_base/btt/nblk     region base, bytes per block, block count
//   err_clr               pulse: leave HALT once nothing is outstanding
//   cmd_tdata/tvalid/tready   command stream to S_AXIS_S2MM_CMD
//   sts_tdata/tkeep/tlast/tvalid/tready  status stream from M_AXIS_S2MM_STS
//   busy, cfg_err, err, err_code, blocks_done, blk_idx  status outputs
// Macro S2MM_SEQ_WRAP_EN: when defined, the region is treated as a ring and
// issuing continues until enable falls or an error occurs; otherwise a run
// issues exactly cfg_nblk commands.
module s2mm_cmd_sequencer
  import s2mm_seq_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      cfg_base,
  input  logic [22:0]      cfg_btt,
  input  logic [15:0]      cfg_nblk,
  input  logic             err_clr,
  output logic [71:0]      cmd_tdata,
  output logic             cmd_tvalid,
  input  logic             cmd_tready,
  input  logic [7:0]       sts_tdata,
  input  logic             sts_tkeep,
  input  logic             sts_tlast,
  input  logic             sts_tvalid,
  output logic             sts_tready,
  output logic             busy,
  output logic             cfg_err,
  output logic             err,
  output logic [4:0]       err_code,
  output logic [CNT_W-1:0] blocks_done,
  output logic [15:0]      blk_idx
);

  localparam logic [3:0] MAX_O = MAX_OUTST[3:0];

  state_e      state;
  logic        enable_q;
  logic [3:0]  outst;
  logic [31:0] addr;
  logic [3:0]  tag;
  logic [22:0] btt;
  logic [15:0] nblk;
`ifdef S2MM_SEQ_WRAP_EN
  logic [31:0] base;
`endif

  logic        hs;
  logic        sts_acc;
  logic        active;
  logic        sts_good;
  logic        sts_bad;
  logic        sts_dec;
  logic        tvalid_hold;
  logic        start;
  logic        cfg_ok;
  logic        chk_good;
  logic [4:0]  chk_err;
  logic [3:0]  exp_tag;
  logic [3:0]  outst_nx;
  logic [31:0] addr_nx;
  logic [15:0] blk_nx;
  logic [3:0]  tag_nx;
  logic        remain_nx;
  logic        can_issue;
  logic        unused_sts_side;

  assign unused_sts_side = ^{sts_tkeep, sts_tlast};

  assign hs          = cmd_tvalid & cmd_tready;
  assign sts_acc     = sts_tvalid & sts_tready;
  assign active      = (state != ST_IDLE);
  assign tvalid_hold = cmd_tvalid & ~cmd_tready;
  assign start       = enable & ~enable_q;
  assign cfg_ok      = (cfg_btt != 23'd0) && (cfg_btt[1:0] == 2'b00) && (cfg_nblk != 16'd0);
  // The oldest outstanding command was issued 'outst' tags ago.
  assign exp_tag     = tag - outst;

  s2mm_sts_check u_sts_check (
    .sts        (sts_tdata),
    .exp_tag    (exp_tag),
    .none_outst (outst == 4'd0),
    .good       (chk_good),
    .err_bits   (chk_err)
  );

  // Status outside IDLE is classified; in IDLE it is drained and ignored.
  assign sts_good  = sts_acc & active & chk_good;
  assign sts_bad   = sts_acc & active & ~chk_good;
  assign sts_dec   = sts_acc & active & (outst != 4'd0);
  // Simultaneous issue and retire leave the count unchanged.
  assign outst_nx  = outst + {3'd0, hs} - {3'd0, sts_dec};

  // Address/tag/index of the command following a handshake.
  always_comb begin
    addr_nx = addr;
    blk_nx  = blk_idx;
    tag_nx  = tag;
    if (hs) begin
      tag_nx = tag + 4'd1;
`ifdef S2MM_SEQ_WRAP_EN
      if (blk_idx == nblk - 16'd1) begin
        addr_nx = base;
        blk_nx  = 16'd0;
      end else begin
        addr_nx = addr + {9'd0, btt};
        blk_nx  = blk_idx + 16'd1;
      end
`else
      addr_nx = addr + {9'd0, btt};
      blk_nx  = blk_idx + 16'd1;
`endif
    end else begin
      tag_nx = tag;
    end
  end

`ifdef S2MM_SEQ_WRAP_EN
  assign remain_nx = 1'b1;
`else
  assign remain_nx = (blk_nx != nblk);
`endif

  assign can_issue = (outst_nx < MAX_O) && remain_nx;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      enable_q    <= 1'b0;
      outst       <= 4'd0;
      addr        <= 32'd0;
      tag         <= 4'd0;
      btt         <= 23'd0;
      nblk        <= 16'd0;
`ifdef S2MM_SEQ_WRAP_EN
      base        <= 32'd0;
`endif
      blk_idx     <= 16'd0;
      cmd_tvalid  <= 1'b0;
      cmd_tdata   <= 72'd0;
      sts_tready  <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      err         <= 1'b0;
      err_code    <= 5'd0;
      blocks_done <= {CNT_W{1'b0}};
    end else begin
      enable_q   <= enable;
      sts_tready <= 1'b1;
      outst      <= outst_nx;
      if (hs) begin
        addr    <= addr_nx;
        tag     <= tag_nx;
        blk_idx <= blk_nx;
      end
      if (sts_good) begin
        blocks_done <= blocks_done + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (state)
        ST_IDLE: begin
          cmd_tvalid <= 1'b0;
          if (start && cfg_ok) begin
            btt         <= cfg_btt;
            nblk        <= cfg_nblk;
`ifdef S2MM_SEQ_WRAP_EN
            base        <= cfg_base;
`endif
            addr        <= cfg_base;
            tag         <= 4'd0;
            blk_idx     <= 16'd0;
            blocks_done <= {CNT_W{1'b0}};
            cfg_err     <= 1'b0;
            err_code    <= 5'd0;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (sts_bad) begin
            err_code   <= chk_err;
            err        <= 1'b1;
            cmd_tvalid <= tvalid_hold;
            state      <= ST_HALT;
          end else if (!enable) begin
            cmd_tvalid <= tvalid_hold;
            state      <= ST_DRAIN;
          end else if (tvalid_hold) begin
            // Command stays presented unchanged until accepted.
            cmd_tvalid <= 1'b1;
          end else if (!remain_nx) begin
            cmd_tvalid <= 1'b0;
            state      <= ST_DRAIN;
          end else if (can_issue) begin
            cmd_tvalid <= 1'b1;
            cmd_tdata  <= build_cmd(tag_nx, addr_nx, btt);
          end else begin
            cmd_tvalid <= 1'b0;
          end
        end

        ST_DRAIN: begin
          cmd_tvalid <= tvalid_hold;
          if (sts_bad) begin
            err_code <= chk_err;
            err      <= 1'b1;
            state    <= ST_HALT;
          end else if ((outst_nx == 4'd0) && !tvalid_hold) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_HALT: begin
          cmd_tvalid <= tvalid_hold;
          if (err_clr && (outst == 4'd0) && !cmd_tvalid) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          cmd_tvalid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s2mm_cmd_sequencer.sv
// tb_s2mm_cmd_sequencer
// Directed bench for s2mm_cmd_sequencer. Expected commands are queued as the
// stimulus is set up; a monitor pops and compares on every command handshake.
// Scalar outputs are compared directly against hand-computed values.
module tb_s2mm_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] cfg_base;
  logic [22:0] cfg_btt;
  logic [15:0] cfg_nblk;
  logic        err_clr;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tkeep;
  logic        sts_tlast;
  logic        sts_tvalid;
  logic        sts_tready;
  logic        busy;
  logic        cfg_err;
  logic        err;
  logic [4:0]  err_code;
  logic [31:0] blocks_done;
  logic [15:0] blk_idx;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  logic [71:0] cmd_exp[$];

  s2mm_cmd_sequencer #(.MAX_OUTST(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_base(cfg_base), .cfg_btt(cfg_btt), .cfg_nblk(cfg_nblk), .err_clr(err_clr),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .sts_tdata(sts_tdata), .sts_tkeep(sts_tkeep), .sts_tlast(sts_tlast),
    .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
    .busy(busy), .cfg_err(cfg_err), .err(err), .err_code(err_code),
    .blocks_done(blocks_done), .blk_idx(blk_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [3:0] t, input logic [31:0] a,
                                     input logic [22:0] b);
    return {4'h0, t, a, 8'h00, 1'b1, b};
  endfunction

  // Scoreboard monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && cmd_tvalid && cmd_tready) begin
      hs_count++;
      if (cmd_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cmd_extra: got %h expected none", cmd_tdata);
      end else begin
        chk("cmd_tdata", cmd_tdata, cmd_exp.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sts(input logic [7:0] b);
    sts_tdata  = b;
    sts_tvalid = 1'b1;
    step(1);
    sts_tvalid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tagname);
    chk({tagname, "_tvalid"}, cmd_tvalid, 1'b0);
    chk({tagname, "_tdata"}, cmd_tdata, 72'd0);
    chk({tagname, "_tready"}, sts_tready, 1'b0);
    chk({tagname, "_busy"}, busy, 1'b0);
    chk({tagname, "_err"}, err, 1'b0);
    chk({tagname, "_errcode"}, err_code, 5'd0);
    chk({tagname, "_cfgerr"}, cfg_err, 1'b0);
    chk({tagname, "_done"}, blocks_done, 32'd0);
    chk({tagname, "_blkidx"}, blk_idx, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
    cfg_base = 32'd0; cfg_btt = 23'd0; cfg_nblk = 16'd0;
    cmd_tready = 1'b0; sts_tdata = 8'd0; sts_tkeep = 1'b1; sts_tlast = 1'b1; sts_tvalid = 1'b0;
    step(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    step(1);
    chk("sts_tready_on", sts_tready, 1'b1);

`ifndef S2MM_SEQ_WRAP_EN
    // 1: one-shot, three blocks, full-rate handshakes
    hs_count = 0;
    cmd_tready = 1'b1;
    cfg_base = 32'h1000; cfg_btt = 23'h400; cfg_nblk = 16'd3;
    for (int k = 0; k < 3; k++) cmd_exp.push_back(mk(k[3:0], 32'h1000 + k * 32'h400, 23'h400));
    enable = 1'b1;
    step(1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_lat_not_yet", cmd_tvalid, 1'b0);
    step(1);
    chk("t1_lat_first", cmd_tvalid, 1'b1);
    step(4);
    chk("t1_hs", hs_count, 3);
    chk("t1_tvalid_off", cmd_tvalid, 1'b0);
    chk("t1_blkidx", blk_idx, 16'd3);
    step(4);
    sts(8'h80); sts(8'h81); sts(8'h82);
    step(1);
    chk("t1_done", blocks_done, 32'd3);
    chk("t1_idle", busy, 1'b0);
    chk("t1_noerr", err, 1'b0);
    chk("t1_q_empty", cmd_exp.size(), 0);
    enable = 1'b0;
    step(1);

    // 2: backpressure and outstanding limit
    hs_count = 0;
    cmd_tready = 1'b0;
    cfg_base = 32'h2000; cfg_btt = 23'h100; cfg_nblk = 16'd8;
    enable = 1'b1;
    step(2);
    chk("t2_valid", cmd_tvalid, 1'b1);
    step(3);
    chk("t2_hold_valid", cmd_tvalid, 1'b1);
    chk("t2_hold_data", cmd_tdata, mk(4'd0, 32'h2000, 23'h100));
    chk("t2_no_hs", hs_count, 0);
    for (int k = 0; k < 5; k++) cmd_exp.push_back(mk(k[3:0], 32'h2000 + k * 32'h100, 23'h100));
    cmd_tready = 1'b1;
    step(8);
    chk("t2_limit_hs", hs_count, 4);
    chk("t2_limit_valid", cmd_tvalid, 1'b0);
    chk("t2_limit_blk", blk_idx, 16'd4);
    sts(8'h80);
    step(2);
    chk("t2_fifth_hs", hs_count, 5);
    chk("t2_fifth_stop", cmd_tvalid, 1'b0);
    chk("t2_q_empty", cmd_exp.size(), 0);
    enable = 1'b0;
    step(1);
    sts(8'h81); sts(8'h82); sts(8'h83); sts(8'h84);
    step(1);
    chk("t2_idle", busy, 1'b0);
    chk("t2_done", blocks_done, 32'd5);

    // 3: SLVERR on the second status
    hs_count = 0;
    cfg_base = 32'h3000; cfg_btt = 23'h40; cfg_nblk = 16'd8;
    for (int k = 0; k < 5; k++) cmd_exp.push_back(mk(k[3:0], 32'h3000 + k * 32'h40, 23'h40));
    enable = 1'b1;
    step(8);
    chk("t3_hs4", hs_count, 4);
    sts(8'h80);
    sts(8'h41);
    chk("t3_err", err, 1'b1);
    chk("t3_code", err_code, 5'b00001);
    chk("t3_stop", cmd_tvalid, 1'b0);
    step(4);
    chk("t3_no_new", cmd_tvalid, 1'b0);
    chk("t3_hs5", hs_count, 5);
    pulse_clr();
    chk("t3_clr_blocked", err, 1'b1);
    sts(8'h82); sts(8'h83); sts(8'h84);
    pulse_clr();
    chk("t3_clr_err", err, 1'b0);
    chk("t3_clr_idle", busy, 1'b0);
    chk("t3_q_empty", cmd_exp.size(), 0);
    enable = 1'b0;
    step(1);

    // 4: tag out of order, then status with nothing outstanding
    hs_count = 0;
    cfg_base = 32'h4000; cfg_btt = 23'h80; cfg_nblk = 16'd2;
    cmd_exp.push_back(mk(4'd0, 32'h4000, 23'h80));
    cmd_exp.push_back(mk(4'd1, 32'h4080, 23'h80));
    enable = 1'b1;
    step(6);
    sts(8'h80);
    sts(8'h82);
    chk("t4_tag_err", err, 1'b1);
    chk("t4_tag_code", err_code, 5'b10000);
    pulse_clr();
    chk("t4_tag_idle", busy, 1'b0);
    enable = 1'b0;
    step(1);
    cmd_tready = 1'b0;
    cfg_base = 32'h5000; cfg_nblk = 16'd1;
    enable = 1'b1;
    step(3);
    chk("t4_pend", cmd_tvalid, 1'b1);
    sts(8'h80);
    chk("t4_unexp_err", err, 1'b1);
    chk("t4_unexp_code", err_code, 5'b01000);
    chk("t4_pend_kept", cmd_tvalid, 1'b1);
    cmd_exp.push_back(mk(4'd0, 32'h5000, 23'h80));
    cmd_tready = 1'b1;
    step(2);
    chk("t4_hs", hs_count, 3);
    sts(8'h80);
    pulse_clr();
    chk("t4_unexp_idle", busy, 1'b0);
    chk("t4_unexp_clr", err, 1'b0);
    enable = 1'b0;
    step(1);
`else
    // 5: ring-buffer addressing with tag rollover
    hs_count = 0;
    cmd_tready = 1'b1;
    cfg_base = 32'h6000; cfg_btt = 23'h10; cfg_nblk = 16'd2;
    for (int k = 0; k < 30; k++) cmd_exp.push_back(mk(k[3:0], 32'h6000 + (k % 2) * 32'h10, 23'h10));
    enable = 1'b1;
    step(6);
    for (int i = 0; i < 20; i++) sts({4'h8, i[3:0]});
    chk("t5_tag_wrap_reached", (hs_count >= 17), 1'b1);
    enable = 1'b0;
    step(2);
    chk("t5_drain_busy", busy, 1'b1);
    for (int j = 20; j < hs_count; j++) sts({4'h8, j[3:0]});
    step(1);
    chk("t5_idle", busy, 1'b0);
    chk("t5_noerr", err, 1'b0);
    chk("t5_done", blocks_done, hs_count);
    cmd_exp.delete();
`endif

    // 6: rejected configurations, then async reset mid-run
    hs_count = 0;
    cmd_tready = 1'b0;
    cfg_base = 32'h7000; cfg_btt = 23'h0; cfg_nblk = 16'd4;
    enable = 1'b1;
    step(3);
    chk("t6_btt0_cfgerr", cfg_err, 1'b1);
    chk("t6_btt0_idle", busy, 1'b0);
    chk("t6_btt0_valid", cmd_tvalid, 1'b0);
    enable = 1'b0;
    step(1);
    cfg_btt = 23'h3;
    enable = 1'b1;
    step(3);
    chk("t6_btt3_cfgerr", cfg_err, 1'b1);
    chk("t6_btt3_valid", cmd_tvalid, 1'b0);
    enable = 1'b0;
    step(1);
    cfg_btt = 23'h100;
    enable = 1'b1;
    step(3);
    chk("t6_ok_cfgerr", cfg_err, 1'b0);
    chk("t6_ok_valid", cmd_tvalid, 1'b1);
    chk("t6_ok_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    enable = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
